mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- Handshaked, iterative AES MixColumns / InvMixColumns engine for the next-generation AES128 datapath.
- It processes COLS_PER_CYCLE 32-bit columns per clock, so area can be traded against latency.
- Forward or inverse mode is selectable per block. This lets one instance serve both encryption and decryption round logic.
- It sits between ShiftRows and AddRoundKey, or between AddRoundKey and InvShiftRows when decrypting.

Parameters:
- COLS_PER_CYCLE, default 1: number of columns transformed per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- INV_EN, default 1: when 1, the inverse-matrix logic is built and IN_INV is honoured. When 0, only forward logic exists and IN_INV is ignored.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- IN_VALID  input  1  IN_DATA/IN_INV are valid.
- IN_READY  output  1  block can accept a new state.
- IN_DATA  input  128  AES state. Column c occupies bits [127-32c : 96-32c]; row 0 is the MSB byte of each column.
- IN_INV  input  1  1 selects InvMixColumns; it is sampled with IN_DATA.
- OUT_VALID  output  1  MIXED_DATA holds a completed result.
- OUT_READY  input  1  downstream accepts the result.
- MIXED_DATA  output  128  transformed state, same byte layout as IN_DATA.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- Arithmetic: GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - Forward matrix rows are circulant rotations of {02,03,01,01}.
  - Inverse matrix rows are circulant rotations of {0e,0b,0d,09}, built from xtime chains. No multipliers or lookup tables.
  - Output byte r of a column = sum over k of M[r][k]·in[(r+k) mod 4].
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - state=IDLE, column counter=0.
  - Working register and MIXED_DATA = 128'h0.
  - OUT_VALID=0, BUSY=0, IN_READY=1 after reset.
  - mode register=0.
- Reset mid-operation aborts the in-flight block with no output.
- State machine IDLE → RUN → DONE → IDLE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch IN_DATA into the working register, latch mode = IN_INV & INV_EN, clear the counter, go to RUN.
- RUN:
  - IN_READY=0.
  - Each cycle, replace columns counter .. counter+COLS_PER_CYCLE-1 of the working register with their transform, then increment the counter by COLS_PER_CYCLE.
  - When the last group is written, go to DONE. RUN lasts exactly 4/COLS_PER_CYCLE cycles (4, 2 or 1).
- DONE:
  - OUT_VALID=1 and MIXED_DATA = working register, both held stable while OUT_READY=0.
  - On OUT_READY: OUT_VALID falls next cycle and state returns to IDLE.
- Latency: accept edge to OUT_VALID high = 4/COLS_PER_CYCLE + 1 cycles. Minimum initiation interval = 4/COLS_PER_CYCLE + 2 cycles.
- IN_VALID while not IN_READY is ignored; the source must hold it.
- IN_DATA/IN_INV changes after the accept edge have no effect.
- The counter is 2 bits and wraps to 0 on leaving RUN; it is never read outside RUN.
- When INV_EN=0, IN_INV=1 gives the forward result.
- OUT_READY asserted in IDLE/RUN is ignored.
- MIXED_DATA retains the last result after the handshake until the next DONE.

Test Plan:
- Reset, then accept IN_DATA=128'hdb135345_f20a225c_01010101_c6c6c6c6, IN_INV=0, OUT_READY=1 → MIXED_DATA=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6. OUT_VALID rises 5/3/2 cycles after accept for COLS_PER_CYCLE=1/2/4.
- IN_DATA=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, IN_INV=1, INV_EN=1 → MIXED_DATA=128'hdb135345_f20a225c_01010101_c6c6c6c6.
- Same stimulus with INV_EN=0 → forward result of that input, i.e. first column 8e4da1bc transformed forward, not db135345.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID → OUT_VALID and MIXED_DATA stable, IN_READY=0, a second IN_VALID is not accepted. Release → IN_READY=1 one cycle later.
- Assert rst_n=0 during RUN (COLS_PER_CYCLE=1, 2nd RUN cycle) → OUT_VALID=0, MIXED_DATA=0, IN_READY=1 immediately, no stale output after release.
- Back-to-back: 100 random states with random IN_INV and random OUT_READY stalls → each result matches the software reference model. Forward-then-inverse of the same state returns the original.

Source files
------------

// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
//   Handshaked, iterative AES MixColumns / InvMixColumns engine. A 128-bit
//   state is latched on accept, transformed COLS_PER_CYCLE columns per RUN
//   cycle in place, then presented on MIXED_DATA until the sink takes it.
//   Forward or inverse mode is chosen per block (inverse only if INV_EN=1).
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   IN_VALID / IN_READY   input handshake; IN_DATA and IN_INV sampled on accept
//   IN_DATA  [127:0]      column c at [127-32c -: 32], row 0 = MSB byte
//   IN_INV                1 = InvMixColumns for this block
//   OUT_VALID / OUT_READY output handshake
//   MIXED_DATA [127:0]    transformed state, held until the next result
//   BUSY                  high while a block is in RUN or DONE
// ---------------------------------------------------------------------------

// One column of the transform. Both matrices are built from xtime chains;
// the inverse half only exists when INV_EN=1.
module mix_col_lane #(
    parameter bit INV_EN = 1'b1
) (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // index = row; row 0 is the MSB byte of the column
    logic [3:0][7:0] a, x2, x4, x8, fwd, inv_o;

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;

        assign a[r]  = col_in[31-8*r -: 8];
        assign x2[r] = xt(a[r]);
        assign x4[r] = xt(x2[r]);
        assign x8[r] = xt(x4[r]);

        // 02·a[r] ^ 03·a[r+1] ^ a[r+2] ^ a[r+3]
        assign fwd[r] = x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];

        // 0e·a[r] ^ 0b·a[r+1] ^ 0d·a[r+2] ^ 09·a[r+3]
        assign inv_o[r] = (x8[r]  ^ x4[r]  ^ x2[r])
                        ^ (x8[R1] ^ x2[R1] ^ a[R1])
                        ^ (x8[R2] ^ x4[R2] ^ a[R2])
                        ^ (x8[R3] ^ a[R3]);
    end

    if (INV_EN) begin : g_inv
        assign col_out = inv ? {inv_o[0], inv_o[1], inv_o[2], inv_o[3]}
                             : {fwd[0], fwd[1], fwd[2], fwd[3]};
    end else begin : g_fwd_only
        wire unused_inv = inv ^ (^inv_o);
        assign col_out = {fwd[0], fwd[1], fwd[2], fwd[3]};
    end
endmodule

module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_INV,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] MIXED_DATA,
    output logic         BUSY
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    // Packed as [3:0][31:0] so column c sits at index ~c (3-c), matching
    // the MSB-first column order of IN_DATA.
    logic [3:0][31:0] work, work_nxt;
    logic [127:0]     mixed_q;
    logic [1:0]       cnt;
    logic             mode;
    logic             last_grp;

    logic [COLS_PER_CYCLE-1:0][1:0]  lane_idx;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

    assign last_grp = (cnt == 2'(4 - COLS_PER_CYCLE));

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
        assign lane_idx[i] = cnt + 2'(i);
        assign lane_in[i]  = work[~lane_idx[i]];
        mix_col_lane #(.INV_EN(INV_EN)) u_lane (
            .col_in  (lane_in[i]),
            .inv     (mode),
            .col_out (lane_out[i])
        );
    end

    // Working register with the current group of columns replaced.
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            work_nxt[~lane_idx[i]] = lane_out[i];
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID)  state_nxt = RUN;
            RUN:     if (last_grp)  state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
        BUSY      = (state == RUN) || (state == DONE);
    end

    // Datapath. The counter wraps to 0 by itself on the last group.
    // The result is copied into mixed_q on the final RUN cycle so it
    // survives the next accept overwriting the working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            mixed_q <= '0;
            cnt     <= 2'd0;
            mode    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    work <= IN_DATA;
                    mode <= IN_INV & INV_EN;
                    cnt  <= 2'd0;
                end
                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt + 2'(COLS_PER_CYCLE);
                    if (last_grp) mixed_q <= work_nxt;
                end
                default: ;
            endcase
        end
    end

    assign MIXED_DATA = mixed_q;
endmodule

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter
//   Four engines share clock and reset: COLS_PER_CYCLE = 1, 2, 4 with the
//   inverse built, and COLS_PER_CYCLE = 1 with the inverse left out.
//   Results are compared with a GF(2^8) matrix-multiply reference.
// ---------------------------------------------------------------------------
module tb_mix_columns_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   iv, inv_i, ordy, ir, ov, busy;
    logic [127:0] din  [4];
    logic [127:0] dout [4];

    int ncols [4] = '{1, 2, 4, 1};
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    mix_columns_iter #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(iv[0]), .IN_READY(ir[0]), .IN_DATA(din[0]),
        .IN_INV(inv_i[0]), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .MIXED_DATA(dout[0]), .BUSY(busy[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(iv[1]), .IN_READY(ir[1]), .IN_DATA(din[1]),
        .IN_INV(inv_i[1]), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .MIXED_DATA(dout[1]), .BUSY(busy[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(iv[2]), .IN_READY(ir[2]), .IN_DATA(din[2]),
        .IN_INV(inv_i[2]), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .MIXED_DATA(dout[2]), .BUSY(busy[2]));
    mix_columns_iter #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(iv[3]), .IN_READY(ir[3]), .IN_DATA(din[3]),
        .IN_INV(inv_i[3]), .OUT_VALID(ov[3]), .OUT_READY(ordy[3]), .MIXED_DATA(dout[3]), .BUSY(busy[3]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // out[r] = sum_k m[k] * in[(r+k) mod 4], per column.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   m   [4];
        logic [7:0]   col [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o ^= gmul(m[k], col[(r+k)%4]);
                res[127-32*c-8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    // Push one block through engine d and check latency, result, stall
    // stability and the return to IDLE. Latency counts clock edges from the
    // accept edge (inclusive) to the edge after which OUT_VALID is high.
    task automatic run_block(input int d, input logic [127:0] data, input bit inv,
                             input int stall, input logic [127:0] exp, input string tag);
        int w, lat;
        din[d]   = data;
        inv_i[d] = inv;
        iv[d]    = 1'b1;
        // OUT_READY raised before DONE must be ignored
        ordy[d]  = (stall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        w = 0;
        while (ir[d] !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        chk({tag, " in_ready"}, ir[d], 1);
        @(posedge clk); #1;
        iv[d]    = 1'b0;
        din[d]   = {$urandom, $urandom, $urandom, $urandom};
        inv_i[d] = 1'($urandom);
        lat = 1;
        while (ov[d] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, lat, 4 / ncols[d] + 1);
        chk({tag, " data"}, dout[d], exp);
        ordy[d] = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // a competing request during DONE must be ignored
            iv[d]  = 1'b1;
            din[d] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk({tag, " stall ov/ir/busy"}, {ov[d], ir[d], busy[d]}, 3'b101);
            chk({tag, " stall data"}, dout[d], exp);
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk({tag, " release ov/ir/busy"}, {ov[d], ir[d], busy[d]}, 3'b010);
        chk({tag, " retained"}, dout[d], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s, f;
        int d;
        bit inv;
        iv = '0; inv_i = '0; ordy = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset ov/ir/busy", {ov[i], ir[i], busy[i]}, 3'b010);
            chk("reset data", dout[i], 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // known vectors on every configuration
        for (int i = 0; i < 3; i++) begin
            run_block(i, V_PLAIN, 1'b0, 0, V_MIXED, "vec fwd");
            run_block(i, V_MIXED, 1'b1, 0, V_PLAIN, "vec inv");
        end
        run_block(3, V_PLAIN, 1'b0, 0, V_MIXED, "noinv fwd");
        run_block(3, V_MIXED, 1'b1, 0, ref_mix(V_MIXED, 1'b0), "noinv inv_req");

        // long backpressure
        run_block(0, V_PLAIN, 1'b0, 10, V_MIXED, "backpressure");

        // reset in the second RUN cycle
        din[0] = V_MIXED; inv_i[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun rst ov/ir/busy", {ov[0], ir[0], busy[0]}, 3'b010);
        chk("midrun rst data", dout[0], 128'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post rst no output", {ov[0], dout[0]}, 129'h0);
        end

        // random traffic with random stalls
        for (int n = 0; n < 100; n++) begin
            d   = n % 4;
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            run_block(d, s, inv, $urandom_range(0, 3), ref_mix(s, inv && d != 3), "random");
        end

        // forward then inverse gives the original state back
        for (int n = 0; n < 10; n++) begin
            d = $urandom_range(0, 2);
            s = {$urandom, $urandom, $urandom, $urandom};
            f = ref_mix(s, 1'b0);
            run_block(d, s, 1'b0, 0, f, "roundtrip fwd");
            run_block(d, f, 1'b1, 0, s, "roundtrip inv");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
